chacha_block_core: RTL and testbench
====================================

Name: chacha_block_core

Overview:
- Iterative ChaCha block function built on the team's combinational quarter-round: 512-bit keystream block from key, nonce and block counter.
- QR_PER_CYCLE quarter-round instances are time-multiplexed over the 16-word working state; ROUNDS is selectable (ChaCha8/12/20).
- Start/busy input handshake, valid/ready output handshake.
- Sits between the stream-cipher controller and the XOR datapath.

Parameters:
- ROUNDS, 20, total rounds; even, 2..20; any other value is an elaboration error.
- QR_PER_CYCLE, 4, quarter-rounds evaluated per clock; legal values 1, 2, 4.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  request a block; accepted only when busy=0
- key  in  256  key words k0..k7; k_i = key[32i+31:32i] (little-endian byte-to-word)
- nonce  in  96  nonce words n0..n2; n_i = nonce[32i+31:32i]
- counter  in  32  block counter
- busy  out  1  high from acceptance until output handshake completes
- out_valid  out  1  block valid
- out_ready  in  1  consumer ready
- block  out  512  keystream; word i = block[32i+31:32i]

Behaviour:
- Reset (async assert, sync deassert): state=IDLE, busy=0, out_valid=0, block=0, all state registers=0. Reset mid-operation aborts the block; no partial output.
- Initial state: w0..w3 = 61707865, 3320646e, 79622d32, 6b206574; w4..w11 = k0..k7; w12 = counter; w13..w15 = n0..n2. key/nonce/counter are sampled only on the acceptance edge; later changes are ignored.
- FSM states: IDLE, ROUND, FINAL, DONE.
- IDLE: start=1 at edge E0 loads initial and working state; go to ROUND; busy=1 from E0.
- ROUND: one step per cycle. A double round is 8 QRs in fixed order:
  - columns (0,4,8,12) (1,5,9,13) (2,6,10,14) (3,7,11,15)
  - then diagonals (0,5,10,15) (1,6,11,12) (2,7,8,13) (3,4,9,14)
  - Each step applies the next QR_PER_CYCLE QRs of that order.
  - Step counter runs S = (ROUNDS/2)*(8/QR_PER_CYCLE) cycles, then go to FINAL.
- FINAL: block <= working + initial, wordwise mod 2^32 with no carry between words; out_valid=1 after this edge; go to DONE.
- Latency: out_valid rises after edge E0+S+1. Defaults: 21 cycles; QR_PER_CYCLE=2: 41; QR_PER_CYCLE=1: 81.
- DONE: block and out_valid are held stable until out_valid&out_ready. On that edge out_valid=0 and busy=0.
  - If start=1 on the same edge, the new request is accepted immediately (back-to-back, E0 of next block).
  - Otherwise go to IDLE.
- start while busy=1, except the DONE handshake edge above: ignored, not queued.
- QR arithmetic: a+=b; d^=a; d<<<=16; c+=d; b^=c; b<<<=12; a+=b; d^=a; d<<<=8; c+=d; b^=c; b<<<=7. All operations are 32-bit mod 2^32.
- Result is bit-identical for every legal QR_PER_CYCLE.

Test Plan:
- RFC 8439 §2.3.2, defaults:
  - Stimulus: key bytes 00..1f (k0=03020100 ... k7=1f1e1d1c); nonce n0=09000000, n1=4a000000, n2=00000000; counter=1; out_ready=1.
  - Required: out_valid exactly 21 cycles after acceptance.
  - Words 0..3 = e4e7f110 15593bd1 1fdd0f50 c47120a3; words 4..7 = c7f4d1c7 0368c033 9aaa2204 4e6cd4c3; words 8..11 = 466482d2 09aa9f07 05d7c214 a2028bd9; words 12..15 = d19c12b5 b94e16de e883d0cb 4e3c50a2.
- Same vector with QR_PER_CYCLE=1 and 2 -> identical block; latency 81 and 41 respectively.
- All-zero key, nonce and counter=0 -> word0 = ade0b876, word1 = 903df1a0 (RFC 8439 A.1 #1).
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> block and out_valid stable, busy=1; start pulses in that window ignored; out_ready=1 -> one transfer, busy=0 next cycle.
- Back-to-back: start=1 with counter=2 on the handshake edge -> second out_valid 21 cycles later; words differ from counter=1 result and match a software model.
- Reset: drop reset_n at cycle 7 of ROUND -> out_valid, busy and block go to 0 immediately (asynchronously); after release, a fresh start gives the correct §2.3.2 result at latency 21.

Source files
------------

// File: rtl/chacha_block_core.sv
// Iterative ChaCha keystream block generator: QR_PER_CYCLE quarter-rounds per clock
// over a 16-word working state. The FSM has four states: IDLE, ROUND, FINAL and DONE.
module chacha_block_core #(
    parameter int ROUNDS       = 20,
    parameter int QR_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [255:0] key,
    input  logic [95:0]  nonce,
    input  logic [31:0]  counter,
    output logic         busy,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] block
);

    localparam int STEPS_PER_DR = 8 / QR_PER_CYCLE;
    localparam int STEPS        = (ROUNDS / 2) * STEPS_PER_DR;
    localparam logic [6:0] STEP_LAST  = 7'(STEPS - 1);
    localparam logic [2:0] PHASE_LAST = 3'(STEPS_PER_DR - 1);

    if (ROUNDS < 2 || ROUNDS > 20 || (ROUNDS % 2) != 0) begin : g_bad_rounds
        $error("chacha_block_core: ROUNDS must be even and in 2..20");
    end
    if (QR_PER_CYCLE != 1 && QR_PER_CYCLE != 2 && QR_PER_CYCLE != 4) begin : g_bad_qpc
        $error("chacha_block_core: QR_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic        load;
    logic        do_step;
    logic        do_final;
    logic [6:0]  step;
    logic [2:0]  phase;
    logic [31:0] init_words [16];
    logic [31:0] init_state [16];
    logic [31:0] work       [16];
    logic [31:0] work_next  [16];
    logic [15:0] lanes;
    logic [127:0] qr_out;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] quarter_round(input logic [31:0] a_in, input logic [31:0] b_in,
                                                   input logic [31:0] c_in, input logic [31:0] d_in);
        logic [31:0] a, b, c, d;
        a = a_in; b = b_in; c = c_in; d = d_in;
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    // Word indices {a,b,c,d} of the idx-th quarter-round of a double round.
    function automatic logic [15:0] qr_lanes(input int idx);
        case (idx)
            0:       return {4'd0, 4'd4, 4'd8,  4'd12};
            1:       return {4'd1, 4'd5, 4'd9,  4'd13};
            2:       return {4'd2, 4'd6, 4'd10, 4'd14};
            3:       return {4'd3, 4'd7, 4'd11, 4'd15};
            4:       return {4'd0, 4'd5, 4'd10, 4'd15};
            5:       return {4'd1, 4'd6, 4'd11, 4'd12};
            6:       return {4'd2, 4'd7, 4'd8,  4'd13};
            default: return {4'd3, 4'd4, 4'd9,  4'd14};
        endcase
    endfunction

    always_comb begin
        init_words[0] = 32'h61707865;
        init_words[1] = 32'h3320646e;
        init_words[2] = 32'h79622d32;
        init_words[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) begin
            init_words[4 + i] = key[32*i +: 32];
        end
        init_words[12] = counter;
        for (int i = 0; i < 3; i++) begin
            init_words[13 + i] = nonce[32*i +: 32];
        end
    end

    // Quarter-rounds in one step touch disjoint words, so chaining them is order-independent.
    always_comb begin
        work_next = work;
        lanes     = '0;
        qr_out    = '0;
        for (int q = 0; q < QR_PER_CYCLE; q++) begin
            lanes  = qr_lanes(int'(phase) * QR_PER_CYCLE + q);
            qr_out = quarter_round(work_next[lanes[15:12]], work_next[lanes[11:8]],
                                   work_next[lanes[7:4]],   work_next[lanes[3:0]]);
            work_next[lanes[15:12]] = qr_out[127:96];
            work_next[lanes[11:8]]  = qr_out[95:64];
            work_next[lanes[7:4]]   = qr_out[63:32];
            work_next[lanes[3:0]]   = qr_out[31:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ROUND;
            ROUND:   if (step == STEP_LAST) state_next = FINAL;
            FINAL:   state_next = DONE;
            DONE:    if (out_ready) state_next = start ? ROUND : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A new block may be accepted on the output handshake edge.
    always_comb begin
        busy      = (state != IDLE);
        out_valid = (state == DONE);
        load      = start && ((state == IDLE) || (state == DONE && out_ready));
        do_step   = (state == ROUND);
        do_final  = (state == FINAL);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                init_state[i] <= '0;
                work[i]       <= '0;
            end
            step  <= '0;
            phase <= '0;
            block <= '0;
        end else begin
            if (load) begin
                init_state <= init_words;
                work       <= init_words;
                step       <= '0;
                phase      <= '0;
            end else if (do_step) begin
                work  <= work_next;
                step  <= step + 7'd1;
                phase <= (phase == PHASE_LAST) ? 3'd0 : phase + 3'd1;
            end
            if (do_final) begin
                for (int i = 0; i < 16; i++) begin
                    block[32*i +: 32] <= work[i] + init_state[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_chacha_block_core.sv
// Self-checking bench for chacha_block_core: RFC 8439 vectors and random vectors are checked
// against a packed-state reference model, along with latency, backpressure and reset behaviour.
module tb_chacha_block_core;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic         start_alt;
    logic [255:0] key;
    logic [95:0]  nonce;
    logic [31:0]  counter;
    logic         out_ready;
    logic         ready_alt = 1'b1;
    logic         busy, out_valid;
    logic [511:0] block;
    logic         busy2, valid2;
    logic [511:0] block2;
    logic         busy1, valid1;
    logic [511:0] block1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    chacha_block_core #(.ROUNDS(20), .QR_PER_CYCLE(4)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .key(key), .nonce(nonce),
        .counter(counter), .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .block(block)
    );
    chacha_block_core #(.ROUNDS(20), .QR_PER_CYCLE(2)) dut_q2 (
        .clk(clk), .reset_n(reset_n), .start(start_alt), .key(key), .nonce(nonce),
        .counter(counter), .busy(busy2), .out_valid(valid2), .out_ready(ready_alt), .block(block2)
    );
    chacha_block_core #(.ROUNDS(20), .QR_PER_CYCLE(1)) dut_q1 (
        .clk(clk), .reset_n(reset_n), .start(start_alt), .key(key), .nonce(nonce),
        .counter(counter), .busy(busy1), .out_valid(valid1), .out_ready(ready_alt), .block(block1)
    );

    task automatic check_value(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [511:0] qr_model(input logic [511:0] st, input int a, input int b,
                                              input int c, input int d);
        logic [31:0] va, vb, vc, vd;
        va = st[32*a +: 32]; vb = st[32*b +: 32]; vc = st[32*c +: 32]; vd = st[32*d +: 32];
        va = va + vb; vd = rotl32(vd ^ va, 16);
        vc = vc + vd; vb = rotl32(vb ^ vc, 12);
        va = va + vb; vd = rotl32(vd ^ va, 8);
        vc = vc + vd; vb = rotl32(vb ^ vc, 7);
        st[32*a +: 32] = va; st[32*b +: 32] = vb; st[32*c +: 32] = vc; st[32*d +: 32] = vd;
        return st;
    endfunction

    function automatic logic [511:0] chacha_model(input logic [255:0] k, input logic [95:0] n,
                                                  input logic [31:0] ctr);
        logic [511:0] init, x, res;
        init = {n, ctr, k, 32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
        x = init;
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 4; i++) begin
                if (r % 2 == 0) x = qr_model(x, i, i + 4, i + 8, i + 12);
                else            x = qr_model(x, i, 4 + (i + 1) % 4, 8 + (i + 2) % 4, 12 + (i + 3) % 4);
            end
        end
        for (int i = 0; i < 16; i++) res[32*i +: 32] = x[32*i +: 32] + init[32*i +: 32];
        return res;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic run_all(output int lat4, output int lat2, output int lat1,
                           output logic [511:0] b4, output logic [511:0] b2, output logic [511:0] b1);
        int cyc;
        lat4 = -1; lat2 = -1; lat1 = -1;
        b4 = '0; b2 = '0; b1 = '0;
        start = 1'b1; start_alt = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start_alt = 1'b0;
        cyc = 0;
        while ((lat4 < 0 || lat2 < 0 || lat1 < 0) && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (lat4 < 0 && out_valid) begin lat4 = cyc; b4 = block;  end
            if (lat2 < 0 && valid2)    begin lat2 = cyc; b2 = block2; end
            if (lat1 < 0 && valid1)    begin lat1 = cyc; b1 = block1; end
        end
        @(posedge clk); #1;
    endtask

    logic [31:0]  rfc_w [16] = '{32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
                                 32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
                                 32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
                                 32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2};

    initial begin
        logic [511:0] rfc_blk, held, first_blk, b4, b2, b1;
        logic [255:0] key_rfc;
        logic [95:0]  nonce_rfc;
        int lat4, lat2, lat1, lat;

        for (int i = 0; i < 16; i++) rfc_blk[32*i +: 32] = rfc_w[i];
        for (int j = 0; j < 32; j++) key_rfc[8*j +: 8] = 8'(j);
        nonce_rfc = {32'h00000000, 32'h4a000000, 32'h09000000};

        reset_n = 1'b0; start = 1'b0; start_alt = 1'b0; out_ready = 1'b1;
        key = '0; nonce = '0; counter = '0;
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_busy", 512'(busy), 512'(0));
        check_value("rst_valid", 512'(out_valid), 512'(0));
        check_value("rst_block", block, '0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // RFC 8439 2.3.2 on all three widths
        key = key_rfc; nonce = nonce_rfc; counter = 32'd1;
        run_all(lat4, lat2, lat1, b4, b2, b1);
        check_value("rfc_lat_q4", 512'(lat4), 512'(21));
        check_value("rfc_lat_q2", 512'(lat2), 512'(41));
        check_value("rfc_lat_q1", 512'(lat1), 512'(81));
        check_value("rfc_blk_q4", b4, rfc_blk);
        check_value("rfc_blk_q2", b2, rfc_blk);
        check_value("rfc_blk_q1", b1, rfc_blk);
        check_value("rfc_model", chacha_model(key_rfc, nonce_rfc, 32'd1), rfc_blk);
        check_value("rfc_busy_after", 512'(busy), 512'(0));

        // RFC 8439 A.1 #1: all-zero inputs
        key = '0; nonce = '0; counter = '0;
        pulse_start();
        wait_valid(lat);
        check_value("zero_lat", 512'(lat), 512'(21));
        check_value("zero_w0", 512'(block[31:0]), 512'(32'hade0b876));
        check_value("zero_w1", 512'(block[63:32]), 512'(32'h903df1a0));
        @(posedge clk); #1;

        for (int t = 0; t < 3; t++) begin
            key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            nonce = {$urandom, $urandom, $urandom};
            counter = $urandom;
            held = chacha_model(key, nonce, counter);
            run_all(lat4, lat2, lat1, b4, b2, b1);
            check_value("rand_lat_q4", 512'(lat4), 512'(21));
            check_value("rand_blk_q4", b4, held);
            check_value("rand_blk_q2", b2, held);
            check_value("rand_blk_q1", b1, held);
        end

        // Backpressure: output held, start pulses ignored
        key = key_rfc; nonce = nonce_rfc; counter = 32'd1;
        out_ready = 1'b0;
        pulse_start();
        wait_valid(lat);
        check_value("bp_lat", 512'(lat), 512'(21));
        held = block;
        check_value("bp_blk", held, rfc_blk);
        for (int i = 0; i < 10; i++) begin
            if (i % 3 == 0) begin
                start = 1'b1;
                counter = $urandom;
            end
            @(posedge clk); #1;
            start = 1'b0;
            check_value("bp_valid_hold", 512'(out_valid), 512'(1));
            check_value("bp_busy_hold", 512'(busy), 512'(1));
            check_value("bp_block_hold", block, held);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_value("bp_valid_drop", 512'(out_valid), 512'(0));
        check_value("bp_busy_drop", 512'(busy), 512'(0));
        @(posedge clk); #1;
        check_value("bp_not_queued", 512'(busy), 512'(0));

        // Back-to-back acceptance on the handshake edge
        out_ready = 1'b0; counter = 32'd1;
        pulse_start();
        wait_valid(lat);
        first_blk = block;
        check_value("b2b_first", first_blk, rfc_blk);
        counter = 32'd2; start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_value("b2b_valid_drop", 512'(out_valid), 512'(0));
        check_value("b2b_busy_kept", 512'(busy), 512'(1));
        wait_valid(lat);
        check_value("b2b_lat", 512'(lat), 512'(21));
        check_value("b2b_blk", block, chacha_model(key_rfc, nonce_rfc, 32'd2));
        check_value("b2b_differs", 512'(block != first_blk), 512'(1));
        @(posedge clk); #1;

        // Asynchronous reset in the middle of ROUND
        counter = 32'd1;
        pulse_start();
        repeat (7) begin @(posedge clk); #1; end
        #2 reset_n = 1'b0;
        #1;
        check_value("arst_valid", 512'(out_valid), 512'(0));
        check_value("arst_busy", 512'(busy), 512'(0));
        check_value("arst_block", block, '0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        pulse_start();
        wait_valid(lat);
        check_value("arst_lat", 512'(lat), 512'(21));
        check_value("arst_blk", block, rfc_blk);
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
